// File: rtl/accum_result_packer.sv
// accum_result_packer
//   Requantizes signed accumulator sums to int8 activations (ReLU, rounding
//   arithmetic right shift, saturation), packs PACK activations per word and
//   buffers the words in a small FIFO drained through a valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   accumulator value present
//   in_ready   value can be accepted this cycle (registered state only)
//   in_data    signed accumulated sum
//   in_last    last value of the feature map; flushes a partial word
//   out_valid  FIFO head word valid
//   out_ready  downstream accepts head word
//   out_data   packed word, lane 0 in the LSBs
//   out_keep   per-lane valid mask of the head word
//   out_last   head word closes the feature map
//   sat_flag   sticky: some value saturated since reset
module accum_result_packer #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK*OUT_WIDTH-1:0] out_data,
    output logic [PACK-1:0]           out_keep,
    output logic                      out_last,
    output logic                      sat_flag
);

    localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned WordW = PACK * OUT_WIDTH;
    localparam int unsigned ExtW  = IN_WIDTH + 1;

    // Requantization, one bit wider than the input so the rounding add never wraps.
    logic signed [ExtW-1:0] ext;
    logic signed [ExtW-1:0] round_c;
    logic signed [ExtW-1:0] max_c;
    logic signed [ExtW-1:0] biased;
    logic signed [ExtW-1:0] shifted;
    logic [OUT_WIDTH-1:0]   q_val;
    logic                   q_sat;

    always_comb begin
        round_c            = '0;
        round_c[SHIFT-1]   = 1'b1;
        max_c              = '0;
        max_c[OUT_WIDTH-2:0] = '1;
        ext     = {in_data[IN_WIDTH-1], in_data};
        biased  = ext + round_c;
        shifted = biased >>> SHIFT;
        q_val   = '0;
        q_sat   = 1'b0;
        if (ext[ExtW-1] || (ext == '0)) begin
            q_val = '0;
        end else if (shifted > max_c) begin
            q_val = max_c[OUT_WIDTH-1:0];
            q_sat = 1'b1;
        end else begin
            q_val = shifted[OUT_WIDTH-1:0];
        end
    end

    // Packing state
    logic [LaneW-1:0] lane_q;
    logic [WordW-1:0] pack_q;
    logic [PACK-1:0]  keep_q;
    logic             sat_q;
    logic [WordW-1:0] pack_merged;
    logic [PACK-1:0]  keep_merged;

    // FIFO state
    logic [WordW-1:0] mem_data [FIFO_DEPTH];
    logic [PACK-1:0]  mem_keep [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;

    logic fifo_full;
    logic accept;
    logic word_done;
    logic push;
    logic pop;

    assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
    // rst gates ready so nothing is taken while state is being cleared.
    assign in_ready  = !rst && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign word_done = (lane_q == LaneW'(PACK - 1)) || in_last;
    assign push      = accept && word_done;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        pack_merged = pack_q;
        pack_merged[lane_q*OUT_WIDTH +: OUT_WIDTH] = q_val;
        keep_merged = keep_q | (PACK'(1) << lane_q);
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q   <= '0;
            pack_q   <= '0;
            keep_q   <= '0;
            sat_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    lane_q <= '0;
                    pack_q <= '0;
                    keep_q <= '0;
                end else begin
                    lane_q <= lane_q + LaneW'(1);
                    pack_q <= pack_merged;
                    keep_q <= keep_merged;
                end
                if (q_sat) begin
                    sat_q <= 1'b1;
                end
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= pack_merged;
            mem_keep[wr_ptr_q] <= keep_merged;
            mem_last[wr_ptr_q] <= in_last;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_keep = out_valid ? mem_keep[rd_ptr_q] : '0;
    assign out_last = out_valid ? mem_last[rd_ptr_q] : 1'b0;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_accum_result_packer.sv
module tb_accum_result_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        sat_flag;

    accum_result_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    word_t exp_q[$];
    int    cur[$];
    bit    sat_exp = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    rand_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ReLU, round-half-up divide by 256, clamp to 127.
    task automatic model_accept(input logic [31:0] v, input logic last);
        longint x;
        longint r;
        logic [31:0] d;
        word_t w;
        x = longint'($signed(v));
        if (x <= 0) begin
            r = 0;
        end else begin
            r = (x + 128) / 256;
            if (r > 127) begin
                r = 127;
                sat_exp = 1'b1;
            end
        end
        cur.push_back(int'(r));
        if (cur.size() == 4 || last) begin
            d = '0;
            for (int i = 0; i < cur.size(); i++) begin
                d = d | (32'(cur[i]) << (8 * i));
            end
            w.data = d;
            w.keep = 4'((1 << cur.size()) - 1);
            w.last = last;
            exp_q.push_back(w);
            cur.delete();
        end
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = v;
        in_last = last;
        while (!done) begin
            @(negedge clk);
            check("sat_flag", 64'(sat_flag), 64'(sat_exp));
            if (in_ready) begin
                model_accept(v, last);
                done = 1'b1;
            end else if (waited > 1000) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        cur.delete();
        sat_exp = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready_high", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [31:0] rand_value();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = -32'($urandom_range(0, 100000));
            1: v = 32'($urandom_range(0, 2000));
            2: v = 32'($urandom_range(0, 40000));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks that a
    // stalled head word does not change.
    word_t       mw;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [3:0]  hold_k;
    logic        hold_l;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(hold_d));
                check("hold_keep", 64'(out_keep), 64'(hold_k));
                check("hold_last", 64'(out_last), 64'(hold_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(out_data), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    mw = exp_q.pop_front();
                    check("word_data", 64'(out_data), 64'(mw.data));
                    check("word_keep", 64'(out_keep), 64'(mw.keep));
                    check("word_last", 64'(out_last), 64'(mw.last));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_k = out_keep;
            hold_l = out_last;
        end
    end

    initial begin
        #2;
        do_reset();
        out_ready = 1'b1;

        // Requantization of single flushed values
        send(32'd896, 1'b1);
        send(32'd895, 1'b1);
        send(-32'sd500, 1'b1);
        wait_drain();
        check("no_sat_yet", 64'(sat_flag), 64'd0);

        // Saturation, then sticky over in-range values
        send(32'h0001_0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send(32'($urandom_range(0, 20000)), 1'($urandom_range(0, 1)));
        end
        send(32'd100, 1'b1);
        wait_drain();
        check("sat_sticky", 64'(sat_flag), 64'd1);

        // Full pack with latency check
        send(32'd256, 1'b0);
        send(32'd512, 1'b0);
        send(32'd768, 1'b0);
        send(32'd1024, 1'b0);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("pack_word", 64'(out_data), 64'h0403_0201);
        check("pack_keep", 64'(out_keep), 64'hF);
        wait_drain();

        // Partial flush, then a new word begins in lane 0
        send(32'd256, 1'b0);
        send(32'd512, 1'b1);
        send(32'd768, 1'b1);
        wait_drain();

        // Backpressure: FIFO fills after 16 accepts
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(32'($urandom_range(1, 30000)), 1'b0);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_pop", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            send(32'($urandom_range(1, 30000)), 1'b0);
        end
        wait_drain();

        // Reset with one word buffered and two values in the packer
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(32'($urandom_range(300, 30000)), 1'b0);
        end
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        check("pre_reset_sat", 64'(sat_flag), 64'd1);
        do_reset();
        out_ready = 1'b1;
        send(32'd2560, 1'b0);
        send(32'd256, 1'b0);
        send(32'd512, 1'b0);
        send(32'd768, 1'b0);
        check("post_reset_lane0", 64'(out_data), 64'h0302_010A);
        wait_drain();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_value(), 1'($urandom_range(0, 7) == 0));
                    if ($urandom_range(0, 4) == 0) begin
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                if (cur.size() != 0) begin
                    send(32'd300, 1'b1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_result_packer.md
# accum_result_packer

Downstream consumer of the output-channel accumulator. Accepts one signed 32-bit accumulated sum (partial sums plus bias) per handshake, then applies ReLU, a rounding arithmetic right shift and saturation to produce int8 activations. Packs four activations into a 32-bit word and buffers the words in a small FIFO. Words leave through a valid/ready port into the feature-map buffer writer for the next layer.

## Interface
- IN_WIDTH, 32, width of the signed accumulator value
- SHIFT, 8, requantization right-shift amount (1..IN_WIDTH-2)
- OUT_WIDTH, 8, width of one packed activation (signed, non-negative after ReLU)
- PACK, 4, activations per output word
- FIFO_DEPTH, 4, output word FIFO entries (power of two)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  accumulator value present
- in_ready  out  1  block can accept a value this cycle
- in_data  in  IN_WIDTH  signed accumulated sum
- in_last  in  1  last value of the feature map; flushes a partial word
- out_valid  out  1  FIFO head word valid
- out_ready  in  1  downstream accepts head word
- out_data  out  PACK*OUT_WIDTH  packed word; lane 0 in LSBs
- out_keep  out  PACK  per-lane valid mask of the head word
- out_last  out  1  head word closes the feature map
- sat_flag  out  1  sticky: some value saturated since reset

## Operation
- An input transfer occurs when in_valid and in_ready are both high at a clock edge. An output transfer occurs when out_valid and out_ready are both high at a clock edge.
- Requantization is computed in IN_WIDTH+1 bits so no intermediate result wraps:
  - if in_data <= 0, the result is 0;
  - otherwise r = (in_data + 2^(SHIFT-1)) >>> SHIFT;
  - if r > 2^(OUT_WIDTH-1)-1, the result is 2^(OUT_WIDTH-1)-1 and sat_flag is set.
- Lane counter `lane` (0..PACK-1) and packing register `pack_q`:
  - each accepted value is written into lane `lane` and lane_keep[lane] is set;
  - if lane == PACK-1 or in_last, the word {pack_q with the current lane merged, keep, in_last} is pushed into the FIFO on the same edge, and lane, pack_q and keep clear to 0;
  - otherwise lane increments.
- Unused lanes of a flushed partial word are zero.
- in_ready = !fifo_full. It is registered-state only, with no combinational path from out_ready. A full FIFO stalls all input, including values that would not complete a word.
- FIFO behaviour:
  - push and pop in the same cycle are both performed, and the occupancy is unchanged;
  - pointers wrap modulo FIFO_DEPTH;
  - out_data, out_keep and out_last reflect the head entry whenever out_valid is high.
- sat_flag is cleared only by rst.

## Timing
- Reset values (rst high at an edge): out_valid 0, out_data 0, out_keep 0, out_last 0, sat_flag 0, FIFO empty, lane 0, pack_q 0. in_ready is 0 while rst is high and 1 in the first cycle after it falls.
- Latency: when the word-completing value is accepted at edge N into an empty FIFO, out_valid is 1 in the cycle after N.
- Throughput: one input per cycle and one word per PACK inputs while out_ready is held high. No bubbles.
- out_valid, out_data, out_keep and out_last hold stable while out_valid is 1 and out_ready is 0.
- When the FIFO is full and out_ready is 1: the pop happens at that edge, and in_ready rises the next cycle.
- rst asserted mid-word or with a non-empty FIFO discards all state and returns to the reset values. No word is emitted.

## Test plan
- Requantization (SHIFT=8), single values each with in_last=1:
  - in_data 896 gives out_data 0x00000004, keep 0x1;
  - in_data 895 gives 0x00000003;
  - in_data -500 gives 0x00000000 with sat_flag still 0.
- Saturation: in_data 0x00010000 gives lane value 0x7F and sat_flag goes to 1. sat_flag then stays 1 after 10 further in-range values.
- Full pack: inputs 256, 512, 768, 1024 on consecutive cycles with in_last=0 on all four. Expect out_data 0x04030201, keep 0xF, last 0, with out_valid rising in the cycle after the 4th accept.
- Partial flush: inputs 256, 512 with in_last on the second. Expect out_data 0x00000201, keep 0x3, last 1. The next word must start in lane 0.
- Backpressure:
  - hold out_ready=0 and stream 20 values; in_ready drops after the 16th accept (4 words buffered);
  - then set out_ready=1; words pop in order, one per cycle;
  - the remaining 4 values complete a 5th word; no value is lost or duplicated.
- Reset mid-operation: after 2 accepted values and 1 buffered word, assert rst for one cycle. out_valid goes to 0 and sat_flag to 0. The next 4 inputs produce a word whose lane 0 is the first post-reset value.
